// File: rtl/instr_cache_pkg.sv
// Shared types for the instruction-cache refill path.
package instr_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    COLLECT,
    WRITE,
    DONE
  } refill_state_t;

  localparam int unsigned REP_WORD_W = 64;

endpackage

// File: rtl/refill_line_buffer.sv
// NB-entry beat store for one cache line; synchronous write, asynchronous read.
module refill_line_buffer
  import instr_cache_pkg::*;
#(
  parameter int unsigned NB = 8,
  parameter int unsigned IW = $clog2(NB)
) (
  input  logic                  clk_i,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_idx,
  input  logic [REP_WORD_W-1:0] wr_data,
  input  logic [IW-1:0]         rd_idx,
  output logic [REP_WORD_W-1:0] rd_data
);

  logic [REP_WORD_W-1:0] mem_q [NB];
  logic [REP_WORD_W-1:0] mem_d [NB];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
  end

  // Data is deliberately not reset; every entry is rewritten before it is read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/instr_cache_refill_ctrl.sv
// L1 instruction miss handler: requests a block from L2, buffers its beats and
// replays them to the cache sets as one unbroken burst.
module instr_cache_refill_ctrl
  import instr_cache_pkg::*;
#(
  parameter int unsigned B      = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  miss_i,
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  l2_req_o,
  output logic [ADDR_W-1:0]     l2_addr_o,
  input  logic                  l2_ack_i,
  input  logic                  l2_rvalid_i,
  input  logic [63:0]           l2_rdata_i,
  output logic                  rep_active_o,
  output logic [63:0]           rep_word_o,
  output logic                  stall_o,
  output logic [31:0]           miss_count_o
);

  localparam int unsigned NB = B / 8;
  localparam int unsigned CW = $clog2(NB);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(B - 1);

  refill_state_t         state_q, state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [ADDR_W-1:0]     l2_addr_q, l2_addr_d;
  logic [31:0]           miss_count_q, miss_count_d;
  logic                  buf_wr_en;
  logic [REP_WORD_W-1:0] buf_rd_data;

  always_comb begin
    state_d      = state_q;
    rx_cnt_d     = rx_cnt_q;
    tx_cnt_d     = tx_cnt_q;
    l2_addr_d    = l2_addr_q;
    miss_count_d = miss_count_q;
    buf_wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_i) begin
          state_d   = REQ;
          l2_addr_d = addr_i & ~OFFSET_MASK;
          rx_cnt_d  = '0;
          if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
        end
      end
      REQ: begin
        if (l2_ack_i) state_d = COLLECT;
      end
      COLLECT: begin
        if (l2_rvalid_i) begin
          buf_wr_en = 1'b1;
          if (rx_cnt_q == LAST_BEAT) begin
            rx_cnt_d = '0;
            tx_cnt_d = '0;
            state_d  = WRITE;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      end
      WRITE: begin
        if (tx_cnt_q == LAST_BEAT) begin
          tx_cnt_d = '0;
          state_d  = DONE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      rx_cnt_q     <= '0;
      tx_cnt_q     <= '0;
      l2_addr_q    <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_cnt_q     <= tx_cnt_d;
      l2_addr_q    <= l2_addr_d;
      miss_count_q <= miss_count_d;
    end
  end

  refill_line_buffer #(
    .NB (NB),
    .IW (CW)
  ) u_line_buf (
    .clk_i   (clk_i),
    .wr_en   (buf_wr_en),
    .wr_idx  (rx_cnt_q),
    .wr_data (l2_rdata_i),
    .rd_idx  (tx_cnt_q),
    .rd_data (buf_rd_data)
  );

  assign l2_req_o     = (state_q == REQ);
  assign l2_addr_o    = l2_addr_q;
  assign rep_active_o = (state_q == WRITE);
  // Masked so the unreset buffer never leaks onto rep_word_o outside a burst.
  assign rep_word_o   = rep_active_o ? buf_rd_data : '0;
  assign stall_o      = miss_i | (state_q != IDLE);
  assign miss_count_o = miss_count_q;

endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// Scoreboard bench for instr_cache_refill_ctrl: driver pushes expected requests
// and beats, a negedge monitor pops and compares them against DUT outputs.
module tb_instr_cache_refill_ctrl;

  localparam int unsigned B      = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NB     = B / 8;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              miss_i;
  logic [ADDR_W-1:0] addr_i;
  logic              l2_req_o;
  logic [ADDR_W-1:0] l2_addr_o;
  logic              l2_ack_i;
  logic              l2_rvalid_i;
  logic [63:0]       l2_rdata_i;
  logic              rep_active_o;
  logic [63:0]       rep_word_o;
  logic              stall_o;
  logic [31:0]       miss_count_o;

  instr_cache_refill_ctrl #(
    .B      (B),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .miss_i       (miss_i),
    .addr_i       (addr_i),
    .l2_req_o     (l2_req_o),
    .l2_addr_o    (l2_addr_o),
    .l2_ack_i     (l2_ack_i),
    .l2_rvalid_i  (l2_rvalid_i),
    .l2_rdata_i   (l2_rdata_i),
    .rep_active_o (rep_active_o),
    .rep_word_o   (rep_word_o),
    .stall_o      (stall_o),
    .miss_count_o (miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  int                exp_len_q[$];
  logic [63:0]       exp_word_q[$];
  logic [31:0]       exp_count;
  bit                in_flight = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: request bursts and replacement bursts against the scoreboard.
  int req_run = 0;
  int act_run = 0;
  always @(negedge clk_i) begin
    logic [ADDR_W-1:0] a;
    int                l;
    if (reset_i) begin
      req_run = 0;
      act_run = 0;
    end else begin
      if (in_flight) chk("stall_busy", 64'(stall_o), 64'd1);
      if (l2_req_o) begin
        req_run++;
        if (exp_addr_q.size() == 0) chk("req_unexpected", 64'(l2_req_o), 64'd0);
        else chk("l2_addr", 64'(l2_addr_o), 64'(exp_addr_q[0]));
      end else if (req_run != 0) begin
        if (exp_len_q.size() > 0) begin
          l = exp_len_q.pop_front();
          a = exp_addr_q.pop_front();
          chk("req_len", 64'(req_run), 64'(l));
        end
        req_run = 0;
      end
      if (rep_active_o) begin
        act_run++;
        if (exp_word_q.size() == 0) chk("word_unexpected", 64'(rep_active_o), 64'd0);
        else chk("rep_word", rep_word_o, exp_word_q.pop_front());
      end else if (act_run != 0) begin
        chk("write_len", 64'(act_run), 64'(NB));
        act_run = 0;
      end
    end
  end

  // One full refill. Starts at a negedge with the DUT idle. gap_mode: 0 none,
  // 1 repeating 0/2/1 idle cycles, 2 random 0..3. seq_base<0 means random data.
  task automatic refill(input logic [ADDR_W-1:0] addr, input int req_len,
                        input int gap_mode, input int seq_base,
                        input bit drop_early, input bit stray, input bit drop_at_done);
    logic [63:0] d;
    int          g;
    int          n;
    int          pat[3] = '{0, 2, 1};
    miss_i = 1'b1;
    addr_i = addr;
    exp_addr_q.push_back((addr / B) * B);
    exp_len_q.push_back(req_len);
    if (exp_count != 32'hFFFF_FFFF) exp_count = exp_count + 32'd1;
    #1;
    chk("stall_on_miss", 64'(stall_o), 64'd1);
    chk("req_low_in_idle", 64'(l2_req_o), 64'd0);
    in_flight = 1'b1;
    @(negedge clk_i);
    for (int c = 1; c < req_len; c++) @(negedge clk_i);
    l2_ack_i = 1'b1;
    @(negedge clk_i);
    l2_ack_i = 1'b0;
    if (drop_early) miss_i = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      if (i == 0) g = 0;
      else if (gap_mode == 1) g = pat[(i - 1) % 3];
      else if (gap_mode == 2) g = int'($urandom_range(3, 0));
      else g = 0;
      for (int k = 0; k < g; k++) begin
        l2_rdata_i = {$urandom, $urandom};
        @(negedge clk_i);
      end
      d = (seq_base < 0) ? {$urandom, $urandom} : 64'(seq_base + i);
      exp_word_q.push_back(d);
      l2_rvalid_i = 1'b1;
      l2_rdata_i  = d;
      @(negedge clk_i);
      l2_rvalid_i = 1'b0;
      l2_rdata_i  = {$urandom, $urandom};
    end
    chk("write_no_bubble", 64'(rep_active_o), 64'd1);
    n = 0;
    while (rep_active_o && n < int'(NB) + 4) begin
      if (stray) begin
        l2_rvalid_i = 1'b1;
        l2_rdata_i  = 64'hDEAD;
      end
      @(negedge clk_i);
      n++;
    end
    l2_rvalid_i = 1'b0;
    if (rep_active_o) chk("write_timeout", 64'(rep_active_o), 64'd0);
    in_flight = 1'b0;
    chk("miss_count", 64'(miss_count_o), 64'(exp_count));
    if (drop_at_done) begin
      miss_i = 1'b0;
      #1;
      chk("stall_in_done", 64'(stall_o), 64'd1);
      @(negedge clk_i);
      chk("stall_released", 64'(stall_o), 64'd0);
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    miss_i      = 1'b0;
    addr_i      = '0;
    l2_ack_i    = 1'b0;
    l2_rvalid_i = 1'b0;
    l2_rdata_i  = '0;
    exp_count   = '0;
    #1;
    chk("rst_req", 64'(l2_req_o), 64'd0);
    chk("rst_addr", 64'(l2_addr_o), 64'd0);
    chk("rst_active", 64'(rep_active_o), 64'd0);
    chk("rst_word", rep_word_o, 64'd0);
    chk("rst_count", 64'(miss_count_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Basic refill, then delayed ack with gappy beats.
    refill(32'h0000_1234, 1, 0, 0, 1'b0, 1'b0, 1'b1);
    refill(32'h0000_5678, 5, 1, 'h100, 1'b0, 1'b0, 1'b1);

    // Back-to-back: miss stays high through DONE with a new address.
    refill(32'h0000_9000, 2, 0, 'h200, 1'b0, 1'b0, 1'b0);
    addr_i = 32'h0000_0040;
    @(negedge clk_i);
    refill(32'h0000_0040, 1, 0, 'h300, 1'b0, 1'b0, 1'b1);

    // Stray beats in IDLE and during WRITE.
    for (int i = 0; i < 2; i++) begin
      l2_rvalid_i = 1'b1;
      l2_rdata_i  = 64'hDEAD;
      @(negedge clk_i);
    end
    l2_rvalid_i = 1'b0;
    refill(32'h0000_ABC0, 3, 1, 'h400, 1'b1, 1'b1, 1'b1);

    // Reset after 3 collected beats; those beats must never be replayed.
    miss_i = 1'b1;
    addr_i = 32'h0000_2000;
    exp_addr_q.push_back(32'h0000_2000);
    exp_len_q.push_back(1);
    @(negedge clk_i);
    l2_ack_i = 1'b1;
    @(negedge clk_i);
    l2_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      l2_rvalid_i = 1'b1;
      l2_rdata_i  = 64'hBAD0 + 64'(i);
      @(negedge clk_i);
    end
    l2_rvalid_i = 1'b0;
    miss_i  = 1'b0;
    reset_i = 1'b1;
    exp_count = '0;
    #1;
    chk("mid_rst_req", 64'(l2_req_o), 64'd0);
    chk("mid_rst_addr", 64'(l2_addr_o), 64'd0);
    chk("mid_rst_active", 64'(rep_active_o), 64'd0);
    chk("mid_rst_word", rep_word_o, 64'd0);
    chk("mid_rst_count", 64'(miss_count_o), 64'd0);
    chk("mid_rst_stall", 64'(stall_o), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    refill(32'h0000_2008, 1, 2, 'h500, 1'b0, 1'b0, 1'b1);

    // Saturation of the refill counter.
    force dut.miss_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.miss_count_q;
    exp_count = 32'hFFFF_FFFE;
    @(negedge clk_i);
    chk("count_preload", 64'(miss_count_o), 64'(exp_count));
    refill(32'h0000_3000, 1, 0, 'h600, 1'b0, 1'b0, 1'b1);
    refill(32'h0000_3040, 2, 0, 'h700, 1'b0, 1'b0, 1'b1);

    // Randomized refills.
    for (int t = 0; t < 8; t++) begin
      refill($urandom, int'($urandom_range(6, 1)), 2, -1,
             1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1);
    end

    repeat (3) @(negedge clk_i);
    chk("words_drained", 64'(exp_word_q.size()), 64'd0);
    chk("reqs_drained", 64'(exp_addr_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_cache_refill_ctrl.md
Name: instr_cache_refill_ctrl

Overview:
- Miss-handling controller between the L1 instruction cache sets and the L2 / memory port.
- On an L1 instruction miss it issues one block request to L2 and collects the 64-bit beats into a line buffer, which absorbs L2 beat gaps.
- It then streams the beats to the cache sets on B/8 back-to-back cycles with rep_active_o high, because a set's replacement counter restarts whenever rep_active drops.
- It holds the fetch stage stalled until the refilled line hits.

Parameters:
- B, 64, block size in bytes; multiple of 8; B/8 >= 2 beats.
- ADDR_W, 32, fetch address width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- miss_i  in  1  OR of all cache_set_miss for the active set
- addr_i  in  ADDR_W  current fetch address (held stable while stall_o=1)
- l2_req_o  out  1  block request valid
- l2_addr_o  out  ADDR_W  block-aligned request address
- l2_ack_i  in  1  L2 accepted request
- l2_rvalid_i  in  1  read beat valid
- l2_rdata_i  in  64  read beat data, lowest address first
- rep_active_o  out  1  drives rep_active_i of the sets
- rep_word_o  out  64  drives rep_word_i of the sets
- stall_o  out  1  freeze PC / fetch
- miss_count_o  out  32  saturating count of refills started

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat counters=0, l2_req_o=0, l2_addr_o=0, rep_active_o=0, rep_word_o=0, miss_count_o=0. Reset mid-refill abandons the refill and discards buffered beats; L2 is assumed reset together with this block.
- Beats per block: NB = B/8. Counter width is $clog2(NB); wraps to 0 after NB-1.
- stall_o = miss_i OR (state != IDLE). Combinational; high in the same cycle a miss appears.
- IDLE:
  - miss_i=1 -> REQ next cycle.
  - Latch l2_addr_o = addr_i with the low $clog2(B) bits zeroed.
  - miss_count_o += 1; saturates at all-ones.
- REQ:
  - l2_req_o=1 and l2_addr_o held until l2_ack_i=1.
  - On ack: l2_req_o=0 next cycle; go to COLLECT.
  - A beat arriving in the ack cycle is invalid; the L2 contract forbids it.
- COLLECT:
  - Each l2_rvalid_i=1 stores l2_rdata_i into buf[rx_cnt]; rx_cnt++.
  - Gaps of any length are allowed.
  - When beat NB-1 is stored -> WRITE next cycle, with tx_cnt=0.
- WRITE:
  - rep_active_o=1 and rep_word_o=buf[tx_cnt] for exactly NB consecutive cycles; tx_cnt++ each cycle.
  - After the cycle with tx_cnt=NB-1 -> DONE.
  - rep_word_o is registered or driven from the buffer. Either way it is valid in the same cycle rep_active_o is high.
- DONE:
  - rep_active_o=0 for one cycle, which lets the set clear its replacement state; then go to IDLE.
  - If miss_i is still 1 in IDLE, a new refill starts. This is legal, e.g. for a different address.
- Stray l2_rvalid_i outside COLLECT is ignored and not stored.
- miss_i dropping during REQ or COLLECT does not cancel the refill; the line is still written.
- Latency from miss to the set's first write: 1 (IDLE->REQ) + ack wait + beat arrival + 1. The block adds no extra bubbles.

Decomposition:
- Shared package (instr_cache_pkg): state enum refill_state_t {IDLE, REQ, COLLECT, WRITE, DONE}; beat width constant REP_WORD_W=64.
- One natural sub-module: refill_line_buffer.
  - NB x 64 register array.
  - Write port: wr_en, wr_idx, wr_data.
  - Asynchronous read port: rd_idx.
  - No reset on the data.

Test Plan:
- Reset mid-COLLECT: reset_i pulse after 3 beats -> all outputs 0, state IDLE. A subsequent miss re-requests from scratch; the old beats never appear.
- Basic refill, B=64: miss at addr_i=0x0000_1234; ack in the first REQ cycle; 8 contiguous beats 0x0..07.
  - l2_addr_o=0x0000_1200.
  - rep_active_o high exactly 8 consecutive cycles with rep_word_o 0x0..00 through 0x0..07 in order.
  - stall_o high from the miss cycle until the miss_i drop that follows DONE.
  - miss_count_o=1.
- Delayed ack and gappy beats: ack after 5 cycles; beats spaced by 0/2/1 idle cycles.
  - l2_req_o high exactly 5 cycles, l2_addr_o stable throughout.
  - WRITE still runs 8 unbroken cycles with the correct data order.
- Back-to-back misses: miss_i still high after DONE with addr_i=0x40 -> second request to 0x40 in the cycle after DONE; miss_count_o=2.
- Stray beats: l2_rvalid_i pulses in IDLE and during WRITE with data 0xDEAD -> buffer contents and rep_word_o unaffected.
- Saturation: preload or force miss_count_o=0xFFFF_FFFF, then one more miss -> remains 0xFFFF_FFFF.
